buffer_fifo: RTL and testbench
==============================

# buffer_fifo

Parametrised synchronous FIFO for data buffering between the link receive/transmit logic and downstream consumers. It wraps a dual-port storage array with write/read pointers, an occupancy counter, threshold flags and sticky error flags, so producers and consumers no longer manage RAM addresses themselves. It has a single clock domain and a registered read port with one-cycle latency.

## Interface
Parameters:
- RAM_WIDTH, 8, data word width in bits
- RAM_ADDR_BITS, 14, address width; depth = 2**RAM_ADDR_BITS words
- ALMOST_FULL_LEVEL, 2**RAM_ADDR_BITS-2, almost_full asserted when level >= this value
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserted when level <= this value

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  RAM_WIDTH  write data
- write_enable  input  1  write request
- read_enable  input  1  read request
- clear_errors  input  1  synchronous clear of overflow/underflow
- data_out  output  RAM_WIDTH  registered read data
- data_valid  output  1  data_out holds a word popped on the previous edge
- full  output  1  level == depth
- empty  output  1  level == 0
- almost_full  output  1  level >= ALMOST_FULL_LEVEL
- almost_empty  output  1  level <= ALMOST_EMPTY_LEVEL
- level  output  RAM_ADDR_BITS+1  current occupancy, 0..depth
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- The design has one clock and an asynchronous, active-high reset. Clock port: clock. Reset port: reset.
- Reset values: write/read pointers 0, level 0, empty 1, almost_empty 1, full 0, almost_full 0, data_out 0, data_valid 0, overflow 0, underflow 0. Storage contents are not reset.
- Write accept: write_enable && !full, where full is the registered flag before the edge. On accept, mem[wptr] <= data_in and wptr <= wptr+1.
- Read accept: read_enable && !empty, where empty is the registered flag before the edge. On accept, data_out <= mem[rptr], rptr <= rptr+1 and data_valid <= 1. Otherwise data_valid <= 0 and data_out holds its value.
- Pointers are RAM_ADDR_BITS wide and wrap modulo depth with no extra logic.
- Level update: +1 on write only, -1 on read only, and unchanged when both are accepted or neither is.
- Simultaneous requests:
  - When full, the read is accepted and the write is rejected, setting overflow. The level drops to depth-1.
  - When empty, the write is accepted and the read is rejected, setting underflow. The level rises to 1, and data_valid stays 0.
  - Otherwise both are accepted.
- Read and write can never address the same slot in one cycle. A read requires level >= 1. At level == depth the write is blocked.
- Flags are registered and computed from the next level value. All flags are consistent with level in the same cycle.
- overflow and underflow set on the rejected request and hold until clear_errors. If clear_errors and a new error event occur on the same edge, the flag stays 1 (set wins).
- Reset asserted mid-operation clears state immediately and asynchronously. The first access after reset release sees an empty FIFO.

## Timing
- Write at edge N: level, empty and almost flags update after edge N. A read may be issued in the cycle after edge N and is accepted at edge N+1.
- Read latency: read accepted at edge N, so data_out and data_valid are valid after edge N and for the cycle that follows.
- Full-to-write-allowed: a read at edge N clears full after edge N, so a write can be accepted at edge N+1.
- Throughput is one write and one read per clock, sustained.
- There are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: RAM_WIDTH=8, RAM_ADDR_BITS=4 (depth 16), ALMOST_FULL_LEVEL=14, ALMOST_EMPTY_LEVEL=2.
- Reset, then idle -> empty=1, almost_empty=1, level=0, data_out=0x00, data_valid=0, full=0, overflow=0, underflow=0.
- Write 0x10..0x1F on 16 consecutive edges -> level counts 1..16. almost_empty falls at level 3, almost_full rises at level 14, full=1 at level 16. A 17th write of 0xAA sets overflow=1 with level staying 16.
- Then read 16 consecutive times -> data_out is 0x10..0x1F in order, one cycle after each accepted read, with data_valid=1 on each. empty=1 after the last read. A 17th read sets underflow=1 with data_valid=0.
- Pointer wrap: write 10, read 10, write 10 words 0x50..0x59, then read 10 -> data returned is 0x50..0x59 in order, and the level peaks at 10.
- Simultaneous access:
  - At level 5, write and read together for 20 cycles -> level stays 5 and output order is preserved.
  - When full, write and read together -> level becomes 15 and overflow=1.
  - When empty, write and read together -> level becomes 1, underflow=1, data_valid=0.
- Sticky errors and reset: clear_errors pulses for one cycle -> both error flags drop to 0. Asserting reset at level 7 mid-stream -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/buffer_fifo_if.sv
// Handshake/status bundle between a producer/consumer and buffer_fifo.
// The FIFO side uses the slave modport; the side driving requests uses master.
interface buffer_fifo_if #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 14
);
  logic [RAM_WIDTH-1:0]   data_in;
  logic                   write_enable;
  logic                   read_enable;
  logic                   clear_errors;
  logic [RAM_WIDTH-1:0]   data_out;
  logic                   data_valid;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [RAM_ADDR_BITS:0] level;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output data_in, write_enable, read_enable, clear_errors,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  data_in, write_enable, read_enable, clear_errors,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/buffer_fifo.sv
// Synchronous FIFO with registered read port, occupancy counter, threshold
// flags and sticky overflow/underflow flags. Single clock, async reset.
module buffer_fifo #(
  parameter int RAM_WIDTH          = 8,
  parameter int RAM_ADDR_BITS      = 14,
  parameter int ALMOST_FULL_LEVEL  = 2**RAM_ADDR_BITS-2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic          clock,
  input  logic          reset,
  buffer_fifo_if.slave  bus
);
  localparam int LW = RAM_ADDR_BITS + 1;
  localparam int AW = RAM_ADDR_BITS;
  localparam logic [LW-1:0] DEPTH     = LW'(2**RAM_ADDR_BITS);
  localparam logic [LW-1:0] AF_LVL    = LW'(ALMOST_FULL_LEVEL);
  localparam logic [LW-1:0] AE_LVL    = LW'(ALMOST_EMPTY_LEVEL);
  localparam logic [LW-1:0] LEVEL_ONE = LW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [RAM_WIDTH-1:0] mem [0:(2**RAM_ADDR_BITS)-1];

  logic [AW-1:0]        wptr_r;
  logic [AW-1:0]        rptr_r;
  logic [LW-1:0]        level_r;
  logic [RAM_WIDTH-1:0] data_out_r;
  logic                 data_valid_r;
  logic                 full_r;
  logic                 empty_r;
  logic                 almost_full_r;
  logic                 almost_empty_r;
  logic                 overflow_r;
  logic                 underflow_r;

  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic [LW-1:0]        level_next_s;

  // Accept decisions use the registered flags, so a full FIFO still pops
  // while blocking the write and an empty FIFO still pushes while blocking the read.
  assign wr_acc_s = bus.write_enable & ~full_r;
  assign rd_acc_s = bus.read_enable  & ~empty_r;

  // Next occupancy: simultaneous accepted push/pop cancel out.
  always_comb begin
    level_next_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_next_s = level_r + LEVEL_ONE;
      2'b01:   level_next_s = level_r - LEVEL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_acc_s) begin
      mem[wptr_r] <= bus.data_in;
    end
  end

  // Pointers, read port, level, threshold flags and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_r         <= '0;
      rptr_r         <= '0;
      level_r        <= '0;
      data_out_r     <= '0;
      data_valid_r   <= 1'b0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        data_out_r   <= mem[rptr_r];
        rptr_r       <= rptr_r + PTR_ONE;
        data_valid_r <= 1'b1;
      end else begin
        data_valid_r <= 1'b0;
      end
      level_r        <= level_next_s;
      full_r         <= (level_next_s == DEPTH);
      empty_r        <= (level_next_s == '0);
      almost_full_r  <= (level_next_s >= AF_LVL);
      almost_empty_r <= (level_next_s <= AE_LVL);
      // A new error on the same edge as clear_errors keeps the flag set.
      overflow_r  <= (bus.write_enable & full_r)  | (overflow_r  & ~bus.clear_errors);
      underflow_r <= (bus.read_enable  & empty_r) | (underflow_r & ~bus.clear_errors);
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.level        = level_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_buffer_fifo.sv
// Directed self-checking bench for buffer_fifo (depth 16, 8-bit words).
module tb_buffer_fifo;
  localparam int W  = 8;
  localparam int AB = 4;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  buffer_fifo_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

  buffer_fifo #(
    .RAM_WIDTH(W), .RAM_ADDR_BITS(AB),
    .ALMOST_FULL_LEVEL(14), .ALMOST_EMPTY_LEVEL(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " empty"},        32'(bus.empty),        32'd1);
    check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
    check({tag, " level"},        32'(bus.level),        32'd0);
    check({tag, " data_out"},     32'(bus.data_out),     32'h00);
    check({tag, " data_valid"},   32'(bus.data_valid),   32'd0);
    check({tag, " full"},         32'(bus.full),         32'd0);
    check({tag, " almost_full"},  32'(bus.almost_full),  32'd0);
    check({tag, " overflow"},     32'(bus.overflow),     32'd0);
    check({tag, " underflow"},    32'(bus.underflow),    32'd0);
  endtask

  task automatic pulse_clear;
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.data_in = 8'h00;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    bus.clear_errors = 1'b0;
    #12 reset = 1'b0;
    tick();
    check_reset_state("reset");

    // Fill 0x10..0x1F, then one write too many
    bus.write_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.data_in = 8'(8'h10 + i);
      tick();
      check("fill level", 32'(bus.level), 32'(i + 1));
      check("fill almost_empty", 32'(bus.almost_empty), 32'((i + 1) <= 2));
      check("fill almost_full", 32'(bus.almost_full), 32'((i + 1) >= 14));
      check("fill full", 32'(bus.full), 32'((i + 1) == 16));
    end
    bus.data_in = 8'hAA;
    tick();
    check("ovf flag", 32'(bus.overflow), 32'd1);
    check("ovf level", 32'(bus.level), 32'd16);
    bus.write_enable = 1'b0;

    // Drain in order, then one read too many
    bus.read_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain data", 32'(bus.data_out), 32'(8'h10 + i));
      check("drain valid", 32'(bus.data_valid), 32'd1);
      check("drain level", 32'(bus.level), 32'(15 - i));
    end
    check("drain empty", 32'(bus.empty), 32'd1);
    tick();
    check("udf flag", 32'(bus.underflow), 32'd1);
    check("udf valid", 32'(bus.data_valid), 32'd0);
    check("udf data hold", 32'(bus.data_out), 32'h1F);
    bus.read_enable = 1'b0;

    pulse_clear();
    check("clr overflow", 32'(bus.overflow), 32'd0);
    check("clr underflow", 32'(bus.underflow), 32'd0);

    // Pointer wrap: 10 in/out, then 0x50..0x59 crosses the end of the array
    bus.write_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 8'(8'h30 + i);
      tick();
    end
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wrap pre data", 32'(bus.data_out), 32'(8'h30 + i));
    end
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 8'(8'h50 + i);
      tick();
    end
    bus.write_enable = 1'b0;
    check("wrap peak level", 32'(bus.level), 32'd10);
    bus.read_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wrap data", 32'(bus.data_out), 32'(8'h50 + i));
    end
    bus.read_enable = 1'b0;
    check("wrap empty", 32'(bus.empty), 32'd1);

    // Simultaneous push/pop at level 5
    bus.write_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_in = 8'(8'h60 + i);
      tick();
    end
    check("sim start level", 32'(bus.level), 32'd5);
    bus.read_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.data_in = 8'(8'h65 + i);
      tick();
      check("sim data", 32'(bus.data_out), 32'(8'h60 + i));
      check("sim level", 32'(bus.level), 32'd5);
    end
    // Holds 0x74..0x78; top up with 0x80..0x8A to full
    bus.read_enable = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.data_in = 8'(8'h80 + i);
      tick();
    end
    check("top-up full", 32'(bus.full), 32'd1);

    // Both requests while full: pop wins, push rejected
    bus.data_in = 8'hBB;
    bus.read_enable = 1'b1;
    tick();
    check("full rw level", 32'(bus.level), 32'd15);
    check("full rw overflow", 32'(bus.overflow), 32'd1);
    check("full rw data", 32'(bus.data_out), 32'h74);
    check("full rw full", 32'(bus.full), 32'd0);
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    pulse_clear();
    check("clr2 overflow", 32'(bus.overflow), 32'd0);

    bus.read_enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("full drain data", 32'(bus.data_out), (i < 4) ? 32'(8'h75 + i) : 32'(8'h80 + i - 4));
    end
    check("full drain empty", 32'(bus.empty), 32'd1);

    // Both requests while empty: push wins, pop rejected
    bus.write_enable = 1'b1;
    bus.data_in = 8'hCC;
    tick();
    check("empty rw level", 32'(bus.level), 32'd1);
    check("empty rw underflow", 32'(bus.underflow), 32'd1);
    check("empty rw valid", 32'(bus.data_valid), 32'd0);
    bus.write_enable = 1'b0;
    tick();
    check("empty rw data", 32'(bus.data_out), 32'hCC);
    check("empty rw valid2", 32'(bus.data_valid), 32'd1);
    bus.read_enable = 1'b0;

    // Asynchronous reset at level 7 with a valid word on data_out
    bus.write_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.data_in = 8'(8'h90 + i);
      tick();
    end
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b1;
    tick();
    bus.read_enable = 1'b0;
    check("pre-rst level", 32'(bus.level), 32'd7);
    check("pre-rst data", 32'(bus.data_out), 32'h90);
    check("pre-rst valid", 32'(bus.data_valid), 32'd1);
    check("pre-rst underflow", 32'(bus.underflow), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("async rst");
    #2 reset = 1'b0;
    tick();
    check_reset_state("post rst");

    bus.write_enable = 1'b1;
    bus.data_in = 8'hDD;
    tick();
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b1;
    tick();
    bus.read_enable = 1'b0;
    check("post rst data", 32'(bus.data_out), 32'hDD);
    check("post rst level", 32'(bus.level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
